// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle computer fetch path: FSM state
// encodings, pcsource select codes and the default reset PC.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } ifu_state_e;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sc_npc.sv
// Next-PC selection for the fetch unit. This block is purely combinational.
// Only inst[25:0] is needed, because the branch offset and the jump index
// both lie in that field.
module sc_npc
  import sc_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [25:0] inst,
  input  logic [31:0] da,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc
);

  always_comb begin
    npc = pc4;
    case (pcsource)
      PCS_SEQ: npc = pc4;
      PCS_BR:  npc = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
      PCS_JR:  npc = da;
      PCS_J:   npc = {pc4[31:28], inst, 2'b00};
      default: npc = pc4;
    endcase
  end

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit. It holds the PC, fetches over a req/ack port and
// presents the current instruction until the core retires it.
// Optional macro SC_IFU_MISALIGN_EN: a misaligned next PC traps into FAULT.
//
// state | meaning
// BOOT  | one cycle after reset, no request
// FETCH | imem_req held with imem_addr = pc until imem_ack
// HOLD  | inst valid, waiting for retire to advance pc
// FAULT | misaligned target trapped, left only by reset
module sc_ifu
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] da,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fault
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic        req_q;
  logic        fault_q;

  logic [31:0] npc;
  logic [31:0] npc_d;
  logic        misalign;

  sc_npc u_npc (
    .pc4      (pc4_q),
    .inst     (inst_q[25:0]),
    .da       (da),
    .pcsource (pcsource),
    .npc      (npc)
  );

`ifdef SC_IFU_MISALIGN_EN
  assign npc_d    = npc;
  assign misalign = |npc[1:0];
`else
  assign npc_d    = npc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      inst_q  <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (retire) begin
            pc_q    <= npc_d;
            pc4_q   <= npc_d + 32'd4;
            valid_q <= 1'b0;
            if (misalign) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              state_q <= ST_FETCH;
              req_q   <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign pc4        = pc4_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_sc_ifu.sv
// Bench for sc_ifu. Fetched words are queued at ack time and compared
// when inst_valid presents them.
module tb_sc_ifu;
  import sc_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] da;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc;
  logic [63:0] sb_q[$];

  sc_ifu dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .da         (da),
    .retire     (retire),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete instruction: fetch with `delay` wait cycles, HOLD for `hold` cycles, then retire.
  task automatic do_instr(input logic [31:0] word, input int delay, input int hold,
                          input logic [1:0] pcs, input logic [31:0] da_v,
                          input logic [31:0] exp_pc);
    int waited;
    logic [63:0] e;
    waited = 0;
    while (!imem_req && waited < 8) begin
      step();
      waited++;
    end
    checks++;
    if (imem_req !== 1'b1 || waited != 0) begin
      errors++;
      $display("FAIL req_start req=%0b waited=%0d required req=1 waited=0", imem_req, waited);
      return;
    end
    checks++;
    if (imem_addr !== model_pc) begin
      errors++;
      $display("FAIL req_addr got=%h exp=%h", imem_addr, model_pc);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_valid_excl inst_valid=%0b exp=0", inst_valid);
    end
    for (int i = 0; i < delay; i++) begin
      retire   = 1'b1;
      pcsource = PCS_J;
      step();
      retire   = 1'b0;
      pcsource = PCS_SEQ;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_stable req=%0b addr=%h valid=%0b exp 1 %h 0",
                 imem_req, imem_addr, inst_valid, model_pc);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    sb_q.push_back({model_pc, word});
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    checks++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_resp valid=%0b req=%0b exp valid=1 req=0", inst_valid, imem_req);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty got=0 exp>0");
    end else begin
      e = sb_q.pop_front();
      if (inst !== e[31:0] || pc !== e[63:32]) begin
        errors++;
        $display("FAIL sb_inst inst=%h pc=%h exp inst=%h pc=%h", inst, pc, e[31:0], e[63:32]);
      end
    end
    for (int i = 0; i < hold; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~word;
      step();
      imem_ack   = 1'b0;
      checks++;
      if (inst !== word || inst_valid !== 1'b1 || imem_req !== 1'b0 || pc !== model_pc) begin
        errors++;
        $display("FAIL hold_stable inst=%h valid=%0b req=%0b pc=%h exp %h 1 0 %h",
                 inst, inst_valid, imem_req, pc, word, model_pc);
      end
    end
    retire   = 1'b1;
    pcsource = pcs;
    da       = da_v;
    step();
    retire   = 1'b0;
    pcsource = PCS_SEQ;
    da       = 32'h0;
    checks++;
    if (pc !== exp_pc || pc4 !== exp_pc + 32'd4 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL retire_pc pc=%h pc4=%h valid=%0b exp pc=%h pc4=%h valid=0",
               pc, pc4, inst_valid, exp_pc, exp_pc + 32'd4);
    end
    model_pc = exp_pc;
  endtask

  task automatic test_reset();
    checks++;
    if (pc !== 32'h0 || pc4 !== 32'h4 || inst !== 32'h0 || inst_valid !== 1'b0 ||
        imem_req !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals pc=%h pc4=%h inst=%h valid=%0b req=%0b fault=%0b exp 0 4 0 0 0 0",
               pc, pc4, inst, inst_valid, imem_req, fault);
    end
    resetn = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_req got=%0b exp=0", imem_req);
    end
    step();
    model_pc = 32'h0;
  endtask

  task automatic test_zero_wait();
    do_instr(32'h2001_0005, 0, 3, PCS_SEQ, 32'h0, 32'h0000_0004);
  endtask

  task automatic test_wait_and_jumps();
    do_instr(32'h0800_0010, 3, 0, PCS_J, 32'h0, 32'h0000_0040);
    do_instr(32'h1000_FFFE, 0, 0, PCS_BR, 32'h0, 32'h0000_003C);
    do_instr(32'h0000_0008, 0, 0, PCS_JR, 32'h1000_0000, 32'h1000_0000);
    do_instr(32'h0800_0100, 0, 0, PCS_J, 32'h0, 32'h1000_0400);
    do_instr(32'h0000_0008, 0, 0, PCS_JR, 32'h0000_0080, 32'h0000_0080);
  endtask

  task automatic test_wrap();
    do_instr(32'h0000_0008, 0, 0, PCS_JR, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_instr(32'h2001_0005, 0, 0, PCS_SEQ, 32'h0, 32'h0000_0000);
  endtask

  task automatic test_misalign();
    logic exp_fault;
`ifdef SC_IFU_MISALIGN_EN
    do_instr(32'h0000_0008, 0, 0, PCS_JR, 32'h0000_0082, 32'h0000_0082);
    exp_fault = 1'b1;
`else
    do_instr(32'h0000_0008, 0, 0, PCS_JR, 32'h0000_0082, 32'h0000_0080);
    exp_fault = 1'b0;
`endif
    checks++;
    if (fault !== exp_fault) begin
      errors++;
      $display("FAIL fault_flag got=%0b exp=%0b", fault, exp_fault);
    end
    if (exp_fault) begin
      for (int i = 0; i < 4; i++) begin
        retire = 1'b1;
        step();
        retire = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fault !== 1'b1 || pc !== 32'h0000_0082) begin
          errors++;
          $display("FAIL fault_hold req=%0b valid=%0b fault=%0b pc=%h exp 0 0 1 00000082",
                   imem_req, inst_valid, fault, pc);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    resetn = 1'b0;
    #2;
    checks++;
    if (pc !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pc=%h valid=%0b req=%0b fault=%0b exp 0 0 0 0",
               pc, inst_valid, imem_req, fault);
    end
    step();
    resetn     = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack   = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL boot_ack_ignored valid=%0b inst=%h req=%0b addr=%h exp 0 0 1 0",
               inst_valid, inst, imem_req, imem_addr);
    end
    sb_q.delete();
    model_pc = 32'h0;
    do_instr(32'h2001_0005, 0, 0, PCS_SEQ, 32'h0, 32'h0000_0004);
  endtask

  initial begin
    resetn     = 1'b0;
    pcsource   = PCS_SEQ;
    da         = 32'h0;
    retire     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    model_pc   = 32'h0;
    step();
    step();
    test_reset();
    test_zero_wait();
    test_wait_and_jumps();
    test_wrap();
    test_misalign();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached exp=finish");
    $fatal(1, "timeout");
  end

endmodule
